// File: rtl/height_pkg.sv
// Shared definitions for the ultrasonic height sensor controller:
// FSM state encoding, history depth, display clamp and default timing
// constants (25 MHz clock), plus the distance-to-height conversion.
package height_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    PUSH,
    HOLDOFF
  } state_t;

  localparam int unsigned HIST_DEPTH     = 10;
  localparam int unsigned MAX_DISPLAY_CM = 99;

  localparam int unsigned DEF_TRIG_CYC    = 250;
  localparam int unsigned DEF_CYC_PER_CM  = 1450;
  localparam int unsigned DEF_ECHO_TO_CYC = 950000;
  localparam int unsigned DEF_HOLDOFF_CYC = 1500000;
  localparam int unsigned DEF_MOUNT_CM    = 200;

  // Height above floor = mount height minus measured distance, floored at 0
  // (object beyond the floor reads as nothing) and clamped to two digits.
  function automatic logic [7:0] height_from_dist(input logic [7:0] dist_cm,
                                                  input int unsigned mount_cm);
    int unsigned h;
    h = (32'(dist_cm) <= mount_cm) ? (mount_cm - 32'(dist_cm)) : 32'd0;
    if (h > MAX_DISPLAY_CM) h = MAX_DISPLAY_CM;
    return 8'(h);
  endfunction

endpackage

// File: rtl/height_sensor_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, reset (async, active-high), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/height_sensor_ctrl.sv
// Ultrasonic height sensor controller: issues a trigger pulse, times the
// echo in cm, converts to height above floor and keeps a 10-deep history.
// Ports: clk, reset (async, active-high), start (measurement request),
// echo (async sensor line), trig (trigger pulse), busy (not idle),
// sample_valid (history shift pulse), timeout_err (aborted measurement),
// hist_0..hist_9 (height history in cm, hist_0 newest).
module height_sensor_ctrl
  import height_pkg::*;
#(
  parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
  parameter int unsigned CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int unsigned ECHO_TO_CYC = DEF_ECHO_TO_CYC,
  parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int unsigned MOUNT_CM    = DEF_MOUNT_CM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       echo,
  output logic       trig,
  output logic       busy,
  output logic       sample_valid,
  output logic       timeout_err,
  output logic [7:0] hist_0,
  output logic [7:0] hist_1,
  output logic [7:0] hist_2,
  output logic [7:0] hist_3,
  output logic [7:0] hist_4,
  output logic [7:0] hist_5,
  output logic [7:0] hist_6,
  output logic [7:0] hist_7,
  output logic [7:0] hist_8,
  output logic [7:0] hist_9
);

  state_t      state, state_nx;
  logic        echo_s, echo_d;
  logic        echo_rise, echo_fall;
  logic        abort;
  logic [31:0] timer;
  logic [31:0] prescale;
  logic [7:0]  dist_cm;
  logic [7:0]  hist [HIST_DEPTH];

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

  // Outputs decoded from the state register so reset removes them at once.
  assign trig         = (state == TRIG);
  assign busy         = (state != IDLE);
  assign sample_valid = (state == PUSH);

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE:      if (start) state_nx = TRIG;
      TRIG:      if (timer == TRIG_CYC - 1) state_nx = WAIT_ECHO;
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_nx = MEASURE;
        end else if (timer == ECHO_TO_CYC - 1) begin
          state_nx = HOLDOFF;
          abort    = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_nx = PUSH;
        end else if (timer == ECHO_TO_CYC - 1) begin
          state_nx = HOLDOFF;
          abort    = 1'b1;
        end
      end
      PUSH:      state_nx = HOLDOFF;
      HOLDOFF:   if (timer == HOLDOFF_CYC - 1) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // The state timer restarts on every transition, so each state measures
  // its own dwell from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      echo_d      <= 1'b0;
      timer       <= '0;
      prescale    <= '0;
      dist_cm     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      echo_d      <= echo_s;
      timeout_err <= abort;
      if (state_nx != state || state == IDLE) timer <= '0;
      else                                    timer <= timer + 32'd1;
      if (state == IDLE && state_nx == TRIG) begin
        prescale <= '0;
        dist_cm  <= '0;
      end else if (state == MEASURE) begin
        if (prescale == CYC_PER_CM - 1) begin
          prescale <= '0;
          if (dist_cm != 8'hFF) dist_cm <= dist_cm + 8'd1;
        end else begin
          prescale <= prescale + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
    end else if (state == PUSH) begin
      for (int unsigned k = HIST_DEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= height_from_dist(dist_cm, MOUNT_CM);
    end
  end

  assign hist_0 = hist[0];
  assign hist_1 = hist[1];
  assign hist_2 = hist[2];
  assign hist_3 = hist[3];
  assign hist_4 = hist[4];
  assign hist_5 = hist[5];
  assign hist_6 = hist[6];
  assign hist_7 = hist[7];
  assign hist_8 = hist[8];
  assign hist_9 = hist[9];

endmodule
